pong_game_sequencer: RTL and testbench
======================================

Name: pong_game_sequencer

Overview:
Top-level game-flow controller for the Pong datapath. It gates the ball and paddle video/motion blocks, and holds and scores the two players' counts. It sequences serve delay, rally, point pause and game-over, paced by frame ticks derived from VSync. It sits beside the sync generator and drives the enables of the ball and both paddle instances.

Parameters:
p_WIN_SCORE, 11, score that ends the game; legal 1..15.
p_SERVE_FRAMES, 60, frame ticks spent in SERVE before the ball is released; legal 1..255.
p_POINT_FRAMES, 90, frame ticks spent in POINT after a miss; legal 1..255.

Ports:
i_Clk  in  1  pixel clock.
i_Reset  in  1  asynchronous reset, active-high.
i_VSync  in  1  vertical sync level from the sync generator.
i_Start  in  1  start button, already debounced; level.
i_Miss_L  in  1  one-cycle pulse: ball passed the left paddle.
i_Miss_R  in  1  one-cycle pulse: ball passed the right paddle.
o_Ball_Enable  out  1  ball may move and be drawn.
o_Paddle_Enable  out  1  paddles respond to player input.
o_Serve_Dir  out  1  serve direction: 0 = toward left, 1 = toward right.
o_Score_L  out  4  left player score.
o_Score_R  out  4  right player score.
o_Game_Over  out  1  high while in OVER.
o_Winner  out  1  valid when o_Game_Over: 0 = left, 1 = right.

Behaviour:
- Clock and reset: one clock, i_Clk. Reset is asynchronous and active-high on i_Reset. All outputs and state are registered.
- Reset values: state=IDLE, both scores 0, frame counter 0, all 1-bit outputs 0, VSync and Start history registers 0.
- Frame tick: one-cycle pulse on the cycle after i_VSync is sampled high while its previous sample was low.
- Start event: same rising-edge detection on i_Start. A held button produces exactly one event.
- States:
  - IDLE: ball and paddles disabled. A Start event clears both scores, sets Serve_Dir=1, clears the frame counter and moves to SERVE.
  - SERVE: paddles enabled, ball disabled. The counter increments per frame tick. On the tick that makes the count equal p_SERVE_FRAMES, clear the counter and move to PLAY. Dwell is exactly p_SERVE_FRAMES ticks.
  - PLAY: ball and paddles enabled.
    - i_Miss_L alone: Score_R+1, Serve_Dir=0.
    - i_Miss_R alone: Score_L+1, Serve_Dir=1.
    - Both misses in the same cycle: treated as a let. No score change, Serve_Dir unchanged, move to POINT.
    - After a scoring miss, if the new score equals p_WIN_SCORE, move to OVER with Winner = the scorer. Otherwise move to POINT.
  - POINT: ball disabled, paddles enabled. Counts p_POINT_FRAMES ticks the same way as SERVE, then moves to SERVE.
  - OVER: ball and paddles disabled, Game_Over=1, scores and Winner held. A Start event clears scores, Game_Over and Winner, sets Serve_Dir=1 and moves to SERVE.
- Output timing: enables and scores update on the clock edge that enters the new state. Latency from a miss pulse to the updated score is 1 cycle.
- Ignored inputs: miss pulses outside PLAY have no effect. Start events outside IDLE and OVER are ignored.
- Boundary conditions:
  - Scores never exceed p_WIN_SCORE; no wrap-around.
  - A frame tick coincident with a miss in PLAY: the miss is handled and the counter is cleared.
  - A Start event and a frame tick in the same cycle in IDLE: go to SERVE with the counter at 0; that tick is not counted.
  - Reset asserted mid-game returns to the reset values immediately, without waiting for a clock edge.

Optional Feature:
ATTRACT_MODE_EN
- Defined: in IDLE, o_Ball_Enable=1 and o_Paddle_Enable=0. Each miss pulse in IDLE toggles Serve_Dir, and scores stay 0. This gives a self-running demo until the first Start event. All other states are unchanged.
- Not defined: o_Ball_Enable=0 in IDLE, and miss pulses are ignored there.

Test Plan:
- Reset, then hold i_Start high for 10 cycles -> exactly one transition to SERVE. Scores 0, Serve_Dir=1, Ball_Enable=0.
- In SERVE with p_SERVE_FRAMES=3, apply 3 VSync rising edges -> Ball_Enable rises the cycle after the 3rd tick, not before.
- In PLAY, pulse i_Miss_L -> next cycle Score_R=1, Serve_Dir=0, Ball_Enable=0. After p_POINT_FRAMES ticks, back in SERVE.
- In PLAY, pulse i_Miss_L and i_Miss_R in the same cycle -> scores unchanged, state POINT, Serve_Dir unchanged.
- Start from Score_L=10 with p_WIN_SCORE=11, pulse i_Miss_R -> Score_L=11, Game_Over=1, Winner=0. Further miss pulses leave the scores at 11/x; a Start event clears the scores and enters SERVE.
- Assert i_Reset asynchronously mid-PLAY with scores 5/7 -> all outputs 0 and state IDLE before the next clock edge.

Source files
------------

// File: rtl/pong_game_sequencer.sv
// pong_game_sequencer: game-flow controller for the Pong datapath.
// Gates the ball and paddle blocks, keeps both scores, and walks through
// serve delay, rally, point pause and game-over, paced by VSync frame ticks.
//
// Optional feature macro: ATTRACT_MODE_EN
//   defined   -> IDLE runs a self-playing demo (ball enabled, paddles off,
//                each miss pulse toggles serve direction, scores stay 0)
//   undefined -> IDLE keeps ball and paddles disabled and ignores misses
//
// state   | meaning
// --------+-----------------------------------------------------------
// s_IDLE  | waiting for the first Start; optional attract demo
// s_SERVE | paddles live, ball held; counting serve-delay frame ticks
// s_PLAY  | rally in progress; miss pulses score points
// s_POINT | paddles live, ball held; counting point-pause frame ticks
// s_OVER  | game finished; scores and winner frozen until Start

module pong_game_sequencer #(
    parameter int p_WIN_SCORE    = 11,
    parameter int p_SERVE_FRAMES = 60,
    parameter int p_POINT_FRAMES = 90
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_VSync,
    input  logic       i_Start,
    input  logic       i_Miss_L,
    input  logic       i_Miss_R,
    output logic       o_Ball_Enable,
    output logic       o_Paddle_Enable,
    output logic       o_Serve_Dir,
    output logic [3:0] o_Score_L,
    output logic [3:0] o_Score_R,
    output logic       o_Game_Over,
    output logic       o_Winner
);

    typedef enum logic [2:0] {
        s_IDLE,
        s_SERVE,
        s_PLAY,
        s_POINT,
        s_OVER
    } state_t;

    localparam logic [3:0] lp_WIN_SCORE  = 4'(p_WIN_SCORE);
    localparam logic [7:0] lp_SERVE_LAST = 8'(p_SERVE_FRAMES - 1);
    localparam logic [7:0] lp_POINT_LAST = 8'(p_POINT_FRAMES - 1);

    state_t     state;
    logic [7:0] frame_cnt;

    logic       vsync_prev;
    logic       frame_tick;
    logic       start_prev;
    logic       start_evt;

    logic [3:0] score_l_inc;
    logic [3:0] score_r_inc;
    logic       serve_done;
    logic       point_done;

    // Saturating increments keep a score from ever passing the winning value.
    assign score_l_inc = (o_Score_L == lp_WIN_SCORE) ? o_Score_L : o_Score_L + 4'd1;
    assign score_r_inc = (o_Score_R == lp_WIN_SCORE) ? o_Score_R : o_Score_R + 4'd1;

    // The tick that would bring the count up to the dwell length ends the dwell.
    assign serve_done = frame_tick && (frame_cnt == lp_SERVE_LAST);
    assign point_done = frame_tick && (frame_cnt == lp_POINT_LAST);

    // Rising-edge detectors: registered one-cycle pulses for VSync and Start.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            vsync_prev <= 1'b0;
            frame_tick <= 1'b0;
            start_prev <= 1'b0;
            start_evt  <= 1'b0;
        end else begin
            vsync_prev <= i_VSync;
            frame_tick <= i_VSync & ~vsync_prev;
            start_prev <= i_Start;
            start_evt  <= i_Start & ~start_prev;
        end
    end

    // Game-flow FSM with registered enables, scores and game-over flags.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state           <= s_IDLE;
            frame_cnt       <= 8'd0;
            o_Ball_Enable   <= 1'b0;
            o_Paddle_Enable <= 1'b0;
            o_Serve_Dir     <= 1'b0;
            o_Score_L       <= 4'd0;
            o_Score_R       <= 4'd0;
            o_Game_Over     <= 1'b0;
            o_Winner        <= 1'b0;
        end else begin
            case (state)
                s_IDLE: begin
`ifdef ATTRACT_MODE_EN
                    o_Ball_Enable   <= 1'b1;
                    o_Paddle_Enable <= 1'b0;
                    // Two simultaneous pulses toggle twice, i.e. no net change.
                    if (i_Miss_L ^ i_Miss_R) begin
                        o_Serve_Dir <= ~o_Serve_Dir;
                    end
`else
                    o_Ball_Enable   <= 1'b0;
                    o_Paddle_Enable <= 1'b0;
`endif
                    // A coincident frame tick is dropped: the counter starts at 0.
                    if (start_evt) begin
                        state           <= s_SERVE;
                        frame_cnt       <= 8'd0;
                        o_Score_L       <= 4'd0;
                        o_Score_R       <= 4'd0;
                        o_Serve_Dir     <= 1'b1;
                        o_Ball_Enable   <= 1'b0;
                        o_Paddle_Enable <= 1'b1;
                    end
                end

                s_SERVE: begin
                    if (serve_done) begin
                        state         <= s_PLAY;
                        frame_cnt     <= 8'd0;
                        o_Ball_Enable <= 1'b1;
                    end else if (frame_tick) begin
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end

                s_PLAY: begin
                    if (i_Miss_L && i_Miss_R) begin
                        // Let: nobody scores, serve direction is kept.
                        state         <= s_POINT;
                        frame_cnt     <= 8'd0;
                        o_Ball_Enable <= 1'b0;
                    end else if (i_Miss_L) begin
                        frame_cnt     <= 8'd0;
                        o_Score_R     <= score_r_inc;
                        o_Serve_Dir   <= 1'b0;
                        o_Ball_Enable <= 1'b0;
                        if (score_r_inc == lp_WIN_SCORE) begin
                            state           <= s_OVER;
                            o_Paddle_Enable <= 1'b0;
                            o_Game_Over     <= 1'b1;
                            o_Winner        <= 1'b1;
                        end else begin
                            state <= s_POINT;
                        end
                    end else if (i_Miss_R) begin
                        frame_cnt     <= 8'd0;
                        o_Score_L     <= score_l_inc;
                        o_Serve_Dir   <= 1'b1;
                        o_Ball_Enable <= 1'b0;
                        if (score_l_inc == lp_WIN_SCORE) begin
                            state           <= s_OVER;
                            o_Paddle_Enable <= 1'b0;
                            o_Game_Over     <= 1'b1;
                            o_Winner        <= 1'b0;
                        end else begin
                            state <= s_POINT;
                        end
                    end
                end

                s_POINT: begin
                    if (point_done) begin
                        state     <= s_SERVE;
                        frame_cnt <= 8'd0;
                    end else if (frame_tick) begin
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end

                s_OVER: begin
                    if (start_evt) begin
                        state           <= s_SERVE;
                        frame_cnt       <= 8'd0;
                        o_Score_L       <= 4'd0;
                        o_Score_R       <= 4'd0;
                        o_Game_Over     <= 1'b0;
                        o_Winner        <= 1'b0;
                        o_Serve_Dir     <= 1'b1;
                        o_Paddle_Enable <= 1'b1;
                    end
                end

                default: begin
                    state           <= s_IDLE;
                    frame_cnt       <= 8'd0;
                    o_Ball_Enable   <= 1'b0;
                    o_Paddle_Enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_sequencer.sv
// Scoreboard bench for pong_game_sequencer: a game-rules model predicts the
// outputs after every clock edge; a monitor compares them against the DUT.

module tb_pong_game_sequencer;

    localparam int WIN   = 11;
    localparam int SERVE = 3;
    localparam int POINT = 4;

    localparam int M_IDLE  = 0;
    localparam int M_SERVE = 1;
    localparam int M_PLAY  = 2;
    localparam int M_POINT = 3;
    localparam int M_OVER  = 4;

    logic       i_Clk = 1'b0;
    logic       i_Reset, i_VSync, i_Start, i_Miss_L, i_Miss_R;
    logic       o_Ball_Enable, o_Paddle_Enable, o_Serve_Dir, o_Game_Over, o_Winner;
    logic [3:0] o_Score_L, o_Score_R;

    typedef struct packed {
        logic       ball;
        logic       paddle;
        logic       dir;
        logic [3:0] sl;
        logic [3:0] sr;
        logic       go;
        logic       win;
    } obs_t;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Game-rules model state
    int m_mode, m_frames_left, m_sl, m_sr, overs_seen;
    bit m_dir, m_win;
    bit vs_hist[2];
    bit st_hist[2];

    pong_game_sequencer #(
        .p_WIN_SCORE   (WIN),
        .p_SERVE_FRAMES(SERVE),
        .p_POINT_FRAMES(POINT)
    ) dut (
        .i_Clk          (i_Clk),
        .i_Reset        (i_Reset),
        .i_VSync        (i_VSync),
        .i_Start        (i_Start),
        .i_Miss_L       (i_Miss_L),
        .i_Miss_R       (i_Miss_R),
        .o_Ball_Enable  (o_Ball_Enable),
        .o_Paddle_Enable(o_Paddle_Enable),
        .o_Serve_Dir    (o_Serve_Dir),
        .o_Score_L      (o_Score_L),
        .o_Score_R      (o_Score_R),
        .o_Game_Over    (o_Game_Over),
        .o_Winner       (o_Winner)
    );

    always #5 i_Clk = ~i_Clk;

    function automatic obs_t dut_obs();
        obs_t o;
        o.ball   = o_Ball_Enable;
        o.paddle = o_Paddle_Enable;
        o.dir    = o_Serve_Dir;
        o.sl     = o_Score_L;
        o.sr     = o_Score_R;
        o.go     = o_Game_Over;
        o.win    = o_Winner;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
`ifdef ATTRACT_MODE_EN
        o.ball = (m_mode == M_PLAY) || (m_mode == M_IDLE);
`else
        o.ball = (m_mode == M_PLAY);
`endif
        o.paddle = (m_mode == M_SERVE) || (m_mode == M_PLAY) || (m_mode == M_POINT);
        o.dir    = m_dir;
        o.sl     = 4'(m_sl);
        o.sr     = 4'(m_sr);
        o.go     = (m_mode == M_OVER);
        o.win    = m_win;
        return o;
    endfunction

    task automatic model_reset();
        m_mode        = M_IDLE;
        m_frames_left = 0;
        m_sl          = 0;
        m_sr          = 0;
        m_dir         = 1'b0;
        m_win         = 1'b0;
        vs_hist       = '{1'b0, 1'b0};
        st_hist       = '{1'b0, 1'b0};
    endtask

    task automatic new_game();
        m_sl          = 0;
        m_sr          = 0;
        m_win         = 1'b0;
        m_dir         = 1'b1;
        m_mode        = M_SERVE;
        m_frames_left = SERVE;
    endtask

    // One clock edge of game rules; the edge is seen one sample late,
    // so this edge acts on "high last edge, low the edge before".
    task automatic model_step(input bit vs, input bit st, input bit ml, input bit mr);
        bit tick, sev;
        tick = vs_hist[0] && !vs_hist[1];
        sev  = st_hist[0] && !st_hist[1];
        vs_hist[1] = vs_hist[0]; vs_hist[0] = vs;
        st_hist[1] = st_hist[0]; st_hist[0] = st;
        case (m_mode)
            M_IDLE: begin
`ifdef ATTRACT_MODE_EN
                if (ml) m_dir = !m_dir;
                if (mr) m_dir = !m_dir;
`endif
                if (sev) new_game();
            end
            M_SERVE: if (tick) begin
                m_frames_left--;
                if (m_frames_left == 0) m_mode = M_PLAY;
            end
            M_PLAY: begin
                if (ml && mr) begin
                    m_mode = M_POINT; m_frames_left = POINT;
                end else if (ml || mr) begin
                    if (ml) begin m_sr++; m_dir = 1'b0; end
                    else    begin m_sl++; m_dir = 1'b1; end
                    if (m_sl == WIN || m_sr == WIN) begin
                        m_mode = M_OVER; m_win = (m_sr == WIN); overs_seen++;
                    end else begin
                        m_mode = M_POINT; m_frames_left = POINT;
                    end
                end
            end
            M_POINT: if (tick) begin
                m_frames_left--;
                if (m_frames_left == 0) begin m_mode = M_SERVE; m_frames_left = SERVE; end
            end
            M_OVER: if (sev) new_game();
            default: m_mode = M_IDLE;
        endcase
        exp_q.push_back(model_obs());
    endtask

    task automatic apply(input bit vs, input bit st, input bit ml, input bit mr);
        i_VSync  = vs;
        i_Start  = st;
        i_Miss_L = ml;
        i_Miss_R = mr;
        model_step(vs, st, ml, mr);
    endtask

    task automatic drive_cycle(input bit vs, input bit st, input bit ml, input bit mr);
        @(negedge i_Clk);
        apply(vs, st, ml, mr);
    endtask

    task automatic check_zero(input string name);
        obs_t got;
        got = dut_obs();
        vectors++;
        if (got != '0) begin
            miscompares++;
            $display("FAIL %s t=%0t got=%h expected=0", name, $time, got);
        end
    endtask

    // Reset asserted between edges must clear outputs before any clock edge.
    task automatic do_async_reset();
        @(negedge i_Clk);
        #2 i_Reset = 1'b1;
        #1 check_zero("async_reset");
        @(negedge i_Clk);
        i_Reset = 1'b0;
        model_reset();
        apply(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frames(input int n, input bit st);
        for (int k = 0; k < n; k++) begin
            drive_cycle(1'b1, st, 1'b0, 1'b0);
            drive_cycle(1'b1, st, 1'b0, 1'b0);
            drive_cycle(1'b0, st, 1'b0, 1'b0);
            drive_cycle(1'b0, st, 1'b0, 1'b0);
        end
    endtask

    // Monitor: after every clock edge, compare against the oldest prediction.
    always @(posedge i_Clk) begin
        obs_t e, g;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = dut_obs();
            vectors++;
            if (g != e) begin
                miscompares++;
                $display("FAIL outputs t=%0t got ball=%b pad=%b dir=%b L=%0d R=%0d go=%b win=%b expected ball=%b pad=%b dir=%b L=%0d R=%0d go=%b win=%b",
                         $time, g.ball, g.paddle, g.dir, g.sl, g.sr, g.go, g.win,
                         e.ball, e.paddle, e.dir, e.sl, e.sr, e.go, e.win);
            end
        end
    end

    initial begin
        bit vs_lvl, st_lvl;
        int vs_timer;
        int r;
        bit ml, mr;

        overs_seen = 0;
        i_Reset = 1'b1; i_VSync = 1'b0; i_Start = 1'b0; i_Miss_L = 1'b0; i_Miss_R = 1'b0;
        #1 check_zero("reset_state");
        repeat (2) @(negedge i_Clk);
        i_Reset = 1'b0;
        model_reset();
        apply(1'b0, 1'b0, 1'b0, 1'b0);

        // Held Start gives one event; a frame edge lands with it.
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        frames(SERVE, 1'b1);
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);          // left miss
        frames(POINT + SERVE, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b1);          // let
        frames(POINT + SERVE, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1);          // miss with VSync rising
        // Right misses drive Score_L to the win, then extra misses are ignored.
        for (int p = 0; p < WIN; p++) begin
            frames(POINT + SERVE, 1'b0);
            drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        end
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);          // restart from OVER
        frames(SERVE, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        do_async_reset();

        vs_lvl = 1'b0; st_lvl = 1'b0; vs_timer = 0;
        for (int n = 0; n < 20000; n++) begin
            if (vs_timer == 0) begin
                vs_lvl = !vs_lvl;
                vs_timer = $urandom_range(1, 4);
            end else begin
                vs_timer--;
            end
            if ($urandom_range(0, 39) == 0) st_lvl = !st_lvl;
            r  = $urandom_range(0, 99);
            ml = (r < 4) || (r == 99);
            mr = (r >= 4 && r < 8) || (r == 99);
            if ($urandom_range(0, 3999) == 0) do_async_reset();
            else drive_cycle(vs_lvl, st_lvl, ml, mr);
        end

        repeat (3) @(posedge i_Clk);
        #5;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got=%0d pending expected=0", exp_q.size());
        end
        vectors++;
        if (overs_seen == 0) begin
            miscompares++;
            $display("FAIL game_over_reached got=0 expected>0");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
